// File: rtl/raster_frame_sequencer.sv
// raster_frame_sequencer
//   Per-frame controller and frame-buffer write-port arbiter for the rasterizer.
//   A frame begins with an optional clear of the whole buffer to the background
//   colour. The write port is then handed to the line generator until end-of-objects
//   has been seen and the generator has fully drained. A one-cycle raster_done
//   pulse closes the frame.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   frame_start_i    1-cycle pulse: begin a frame (honoured in IDLE only)
//   eoo_i            1-cycle pulse: end of objects for the current frame
//   clear_en_i       sampled with frame_start_i: clear the buffer before drawing
//   bk_color_i[2:0]  background colour, sampled with frame_start_i
//   lg_req_i         line generator presents a pixel
//   lg_x_i[9:0]      pixel x
//   lg_y_i[8:0]      pixel y
//   lg_color_i[2:0]  pixel colour
//   lg_idle_i        line generator has nothing in flight and an empty FIFO
//   lg_gnt_o         pixel accepted this cycle
//   fb_ready_i       frame buffer accepts a write this cycle
//   fb_wr_en_o       write request to the frame buffer
//   fb_x_o[9:0]      write x
//   fb_y_o[8:0]      write y
//   fb_color_o[2:0]  write colour
//   raster_ready_o   upstream may push lines (CLEAR and DRAW)
//   raster_done_o    1-cycle pulse: frame complete
//   busy_o           sequencer is not idle
module raster_frame_sequencer #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       eoo_i,
  input  logic       clear_en_i,
  input  logic [2:0] bk_color_i,
  input  logic       lg_req_i,
  input  logic [9:0] lg_x_i,
  input  logic [8:0] lg_y_i,
  input  logic [2:0] lg_color_i,
  input  logic       lg_idle_i,
  output logic       lg_gnt_o,
  input  logic       fb_ready_i,
  output logic       fb_wr_en_o,
  output logic [9:0] fb_x_o,
  output logic [8:0] fb_y_o,
  output logic [2:0] fb_color_o,
  output logic       raster_ready_o,
  output logic       raster_done_o,
  output logic       busy_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_DRAW  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  logic [2:0] state_q, state_d;
  logic [9:0] cnt_x_q, cnt_x_d;
  logic [8:0] cnt_y_q, cnt_y_d;
  logic       eoo_seen_q, eoo_seen_d;
  logic [2:0] bk_q, bk_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      eoo_seen_q <= 1'b0;
      bk_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      eoo_seen_q <= eoo_seen_d;
      bk_q       <= bk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_x_d    = cnt_x_q;
    cnt_y_d    = cnt_y_q;
    eoo_seen_d = eoo_seen_q;
    bk_d       = bk_q;
    case (state_q)
      ST_IDLE: begin
        // A lone eoo in IDLE belongs to no frame and is dropped; one that
        // coincides with frame_start is remembered for the new frame.
        if (frame_start_i) begin
          bk_d       = bk_color_i;
          eoo_seen_d = eoo_i;
          cnt_x_d    = '0;
          cnt_y_d    = '0;
          state_d    = clear_en_i ? ST_CLEAR : ST_DRAW;
        end
      end
      ST_CLEAR: begin
        if (eoo_i) begin
          eoo_seen_d = 1'b1;
        end
        // The address only moves on an accepted write, so stalls never skip
        // or repeat a pixel.
        if (fb_ready_i) begin
          if (cnt_x_q == X_LAST) begin
            cnt_x_d = '0;
            if (cnt_y_q == Y_LAST) begin
              cnt_y_d = '0;
              state_d = ST_DRAW;
            end else begin
              cnt_y_d = cnt_y_q + 9'd1;
            end
          end else begin
            cnt_x_d = cnt_x_q + 10'd1;
          end
        end
      end
      ST_DRAW: begin
        // Any eoo remembered from IDLE/CLEAR is consumed here.
        eoo_seen_d = 1'b0;
        if (eoo_i || eoo_seen_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (lg_idle_i && !lg_req_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lg_gnt_o       = 1'b0;
    fb_wr_en_o     = 1'b0;
    fb_x_o         = '0;
    fb_y_o         = '0;
    fb_color_o     = '0;
    raster_ready_o = 1'b0;
    raster_done_o  = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    case (state_q)
      ST_CLEAR: begin
        fb_wr_en_o     = 1'b1;
        fb_x_o         = cnt_x_q;
        fb_y_o         = cnt_y_q;
        fb_color_o     = bk_q;
        raster_ready_o = 1'b1;
      end
      ST_DRAW, ST_DRAIN: begin
        fb_wr_en_o     = lg_req_i;
        fb_x_o         = lg_req_i ? lg_x_i : 10'd0;
        fb_y_o         = lg_req_i ? lg_y_i : 9'd0;
        fb_color_o     = lg_req_i ? lg_color_i : 3'd0;
        lg_gnt_o       = lg_req_i & fb_ready_i;
        raster_ready_o = (state_q == ST_DRAW);
      end
      ST_DONE: raster_done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// Bench for raster_frame_sequencer with a reduced raster so full clears stay short.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. The reference is a phase-by-phase walk of the frame: the clear
// phase expects write number k at (k mod H, k div H).
module tb_raster_frame_sequencer;

  localparam int H = 16;
  localparam int V = 8;
  localparam int NPIX = H * V;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, eoo, clear_en, lg_req, lg_idle, fb_ready;
  logic [2:0] bk_color, lg_color;
  logic [9:0] lg_x;
  logic [8:0] lg_y;
  logic       lg_gnt, fb_wr_en, raster_ready, raster_done, busy;
  logic [9:0] fb_x;
  logic [8:0] fb_y;
  logic [2:0] fb_color;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  raster_frame_sequencer #(.H_RES(H), .V_RES(V)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .frame_start_i(frame_start), .eoo_i(eoo), .clear_en_i(clear_en),
    .bk_color_i(bk_color),
    .lg_req_i(lg_req), .lg_x_i(lg_x), .lg_y_i(lg_y), .lg_color_i(lg_color),
    .lg_idle_i(lg_idle), .lg_gnt_o(lg_gnt),
    .fb_ready_i(fb_ready), .fb_wr_en_o(fb_wr_en), .fb_x_o(fb_x), .fb_y_o(fb_y),
    .fb_color_o(fb_color), .raster_ready_o(raster_ready),
    .raster_done_o(raster_done), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ew, input logic [9:0] ex,
                            input logic [8:0] ey, input logic [2:0] ec, input logic eg,
                            input logic er, input logic ed, input logic eb);
    check({tag, ".wr_en"}, 32'(fb_wr_en), 32'(ew));
    check({tag, ".x"}, 32'(fb_x), 32'(ex));
    check({tag, ".y"}, 32'(fb_y), 32'(ey));
    check({tag, ".color"}, 32'(fb_color), 32'(ec));
    check({tag, ".gnt"}, 32'(lg_gnt), 32'(eg));
    check({tag, ".ready"}, 32'(raster_ready), 32'(er));
    check({tag, ".done"}, 32'(raster_done), 32'(ed));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic rand_lg;
    lg_x     = 10'($urandom);
    lg_y     = 9'($urandom);
    lg_color = 3'($urandom);
  endtask

  task automatic quiet;
    frame_start = 0; eoo = 0; clear_en = 0; bk_color = 0;
    lg_req = 0; lg_x = 0; lg_y = 0; lg_color = 0; lg_idle = 1; fb_ready = 1;
  endtask

  // Pixel-port expectation shared by DRAW and DRAIN.
  task automatic check_draw_port(input string tag, input logic rr);
    check_outs(tag, lg_req, lg_req ? lg_x : 10'd0, lg_req ? lg_y : 9'd0,
               lg_req ? lg_color : 3'd0, lg_req & fb_ready, rr, 1'b0, 1'b1);
  endtask

  // One complete frame.
  //   clr       clear before drawing; bk background colour
  //   eoo_start eoo together with frame_start
  //   eoo_k     pulse eoo in CLEAR while write index k is presented (-1: never)
  //   n_draw    DRAW length when no eoo is pending (eoo on its last cycle)
  //   dir3      first three DRAW cycles: pixel (100,200,2) with fb_ready 0,0,1
  //   n_drain   extra busy DRAIN cycles before drain completes (-1: random)
  //   rnd_rdy   randomise fb_ready during the clear
  task automatic run_frame(input string name, input bit clr, input logic [2:0] bk,
                           input bit eoo_start, input int eoo_k, input int n_draw,
                           input bit dir3, input int n_drain, input bit rnd_rdy);
    int  k, budget, nd, m, f0, cyc;
    bit  pend;
    f0  = n_fail;
    cyc = 0;
    frame_start = 1; clear_en = clr; bk_color = bk; eoo = eoo_start;
    lg_req = 1'($urandom); rand_lg(); fb_ready = 1'($urandom);
    sample;
    check_outs({name, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
    tick; cyc++;
    frame_start = 0; eoo = 0; clear_en = 1'($urandom); bk_color = 3'($urandom);
    pend = eoo_start;
    if (clr) begin
      k = 0; budget = 0;
      while (k < NPIX && budget < NPIX * 8) begin
        fb_ready    = rnd_rdy ? 1'($urandom) : 1'b1;
        eoo         = (k == eoo_k) && !pend;
        frame_start = 1'($urandom);
        lg_req      = 1'($urandom); rand_lg();
        sample;
        check_outs({name, ".clear"}, 1, 10'(k % H), 9'(k / H), bk, 0, 1, 0, 1);
        if (eoo) pend = 1;
        if (fb_ready) k++;
        budget++;
        tick; cyc++;
      end
      if (k != NPIX) check({name, ".clear_budget"}, k, NPIX);
    end
    nd = pend ? 1 : n_draw;
    for (int i = 0; i < nd; i++) begin
      if (dir3 && i < 3) begin
        lg_req = 1; lg_x = 10'd100; lg_y = 9'd200; lg_color = 3'b010;
        fb_ready = (i == 2);
      end else begin
        lg_req = 1'($urandom); rand_lg(); fb_ready = 1'($urandom);
      end
      eoo = !pend && (i == nd - 1);
      frame_start = 1'($urandom);
      lg_idle = 1'($urandom);
      sample;
      check_draw_port({name, ".draw"}, 1'b1);
      tick; cyc++;
    end
    m = (n_drain < 0) ? $urandom_range(0, 4) : n_drain;
    for (int j = 0; j <= m; j++) begin
      if (j < m) begin
        lg_req = 1'($urandom);
        lg_idle = lg_req ? 1'($urandom) : 1'b0;
      end else begin
        lg_req = 0; lg_idle = 1;
      end
      rand_lg(); fb_ready = 1'($urandom);
      eoo = 1'($urandom); frame_start = 1'($urandom);
      sample;
      check_draw_port({name, ".drain"}, 1'b0);
      tick; cyc++;
    end
    lg_req = 1'($urandom); rand_lg(); fb_ready = 1'($urandom);
    eoo = 1'($urandom); frame_start = 1'($urandom);
    sample;
    check_outs({name, ".done"}, 0, 0, 0, 0, 0, 0, 1, 1);
    tick; cyc++;
    // Lone eoo in IDLE must not start anything.
    frame_start = 0; eoo = 1; lg_req = 1'($urandom); lg_idle = 1;
    sample;
    check_outs({name, ".idle_after"}, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    quiet();
    $display("[TB] frame %s clr=%0d bk=%0d cycles=%0d new_fails=%0d",
             name, clr, bk, cyc, n_fail - f0);
  endtask

  task automatic reset_mid_clear(input int k_tgt);
    int f0;
    f0 = n_fail;
    frame_start = 1; clear_en = 1; bk_color = 3'd7;
    sample;
    tick;
    frame_start = 0; fb_ready = 1;
    for (int k = 0; k < k_tgt; k++) begin
      sample;
      check_outs("rst.clear", 1, 10'(k % H), 9'(k / H), 3'd7, 0, 1, 0, 1);
      tick;
    end
    sample;
    check_outs("rst.target", 1, 10'(k_tgt % H), 9'(k_tgt / H), 3'd7, 0, 1, 0, 1);
    rst_n = 0;
    #1;
    check_outs("rst.async", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      frame_start = 1; lg_req = 1; eoo = 1'($urandom); rand_lg();
      sample;
      check_outs("rst.held", 0, 0, 0, 0, 0, 0, 0, 0);
    end
    tick;
    quiet();
    rst_n = 1;
    sample;
    check_outs("rst.released", 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    $display("[TB] frame rst_abort at (%0d,%0d) new_fails=%0d",
             k_tgt % H, k_tgt / H, n_fail - f0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    rst_n = 0;
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    rst_n = 1;
    tick;
    run_frame("t1_clear_ready", 1, 3'b101, 0, -1, 4, 0, -1, 0);
    run_frame("t2_clear_stall", 1, 3'($urandom), 0, -1, 5, 0, -1, 1);
    run_frame("t3_draw_stall", 0, 3'($urandom), 0, -1, 6, 1, -1, 1);
    run_frame("t4_eoo_in_clear", 1, 3'b011, 0, NPIX / 2, 5, 0, 0, 1);
    run_frame("t5_eoo_with_start", 0, 3'b001, 1, -1, 5, 0, 0, 1);
    reset_mid_clear(4 * H + H / 2);
    run_frame("t6_restart", 1, 3'b110, 0, -1, 3, 0, -1, 1);
    for (int r = 0; r < 4; r++) begin
      run_frame("rand", 1'($urandom), 3'($urandom), 1'($urandom),
                $urandom_range(0, NPIX + 8), $urandom_range(1, 8), 0, -1, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
